// File: rtl/mem_pkg.sv
// Shared types for the memory target: FSM states, default widths and the
// latched request record.
package mem_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Sized by the package defaults; keep them in step with any parameter override.
    typedef struct packed {
        logic                      wr_rd;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0]      wdata;
    } cmd_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port; the whole array and the read register clear on reset.
module mem_array #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // rdata_q only moves on a read strobe, so it holds between reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory target: accepts one valid/ready request at a time, waits WAIT_STATES
// cycles, then completes with a one-cycle ready pulse (plus rdata for reads).
module mem_slave_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic [1:0]            state_o
);

    // Handshake: the master holds valid with a stable command until it samples
    // ready high; valid dropping before completion aborts the request, and the
    // RESP cycle ignores valid so every completion is followed by one bubble.

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cmd_t       cmd_q, cmd_d;
    logic       ready_q, ready_d;
    logic       mem_we, mem_re;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    cmd_d.wr_rd = wr_rd;
                    cmd_d.addr  = addr;
                    cmd_d.wdata = wdata;
                    cnt_d       = 4'(WAIT_STATES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    mem_we  = cmd_q.wr_rd;
                    mem_re  = !cmd_q.wr_rd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk_i   (clk),
        .rst_n_i (rst),
        .we_i    (mem_we),
        .waddr_i (cmd_q.addr),
        .wdata_i (cmd_q.wdata),
        .re_i    (mem_re),
        .raddr_i (cmd_q.addr),
        .rdata_o (rdata)
    );

    assign ready   = ready_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Bench for mem_slave_ctrl: one instance with two wait states (side A) and one
// with none (side B), driven from a vector table plus hand-written corner cases.
module tb_mem_slave_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       valid_a, wr_rd_a, ready_a;
    logic [3:0] addr_a;
    logic [7:0] wdata_a, rdata_a;
    logic [1:0] state_a;
    logic       valid_b, wr_rd_b, ready_b;
    logic [3:0] addr_b;
    logic [7:0] wdata_b, rdata_b;
    logic [1:0] state_b;

    mem_slave_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .rst(rst), .valid(valid_a), .wr_rd(wr_rd_a), .addr(addr_a),
        .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .state_o(state_a)
    );

    mem_slave_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst(rst), .valid(valid_b), .wr_rd(wr_rd_b), .addr(addr_b),
        .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b), .state_o(state_b)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit         sel;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit wr, input logic [3:0] a,
                         input logic [7:0] d);
        if (sel) begin
            valid_b = v; wr_rd_b = wr; addr_b = a; wdata_b = d;
        end else begin
            valid_a = v; wr_rd_a = wr; addr_a = a; wdata_a = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    function automatic logic [7:0] rd(input bit sel);
        return sel ? rdata_b : rdata_a;
    endfunction

    // One complete request from IDLE: latency, rdata, single-cycle pulse, hold.
    task automatic do_req(input bit sel, input bit wr, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input string name);
        int         lat;
        logic [7:0] exp;
        @(negedge clk);
        drive(sel, 1'b1, wr, a, d);
        exp_q.push_back(exp_rd);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (rdy(sel)) begin
                lat = c;
                break;
            end
        end
        exp = exp_q.pop_front();
        check({name, " latency"}, lat, sel ? 32'd2 : 32'd4);
        check({name, " rdata"}, rd(sel), exp);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk); #1;
        check({name, " pulse_end"}, rdy(sel), 1'b0);
        check({name, " rdata_hold"}, rd(sel), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bit         seen;
        logic [7:0] e;

        vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 4'h9, 8'h3C, 8'hA5};
        vecs[3] = '{1'b0, 1'b0, 4'h9, 8'h00, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[5] = '{1'b1, 1'b1, 4'hF, 8'h5A, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h5A};
        vecs[7] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h00};

        // Reset state
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst ready_a", ready_a, 1'b0);
        check("rst rdata_a", rdata_a, 8'h00);
        check("rst state_a", state_a, IDLE);
        check("rst ready_b", ready_b, 1'b0);
        check("rst rdata_b", rdata_b, 8'h00);
        check("rst state_b", state_b, IDLE);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 1'b0, 4'h7, 8'h00, 8'h00, "rd7_after_rst");

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
                   $sformatf("vec%0d", i));
        end

        // Back-to-back on the zero-wait side: second request accepted at E3
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 4'hE, 8'h11);
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        check("b2b e0 ready", ready_b, 1'b0);
        @(posedge clk); #1;
        check("b2b e1 ready", ready_b, 1'b1);
        e = exp_q.pop_front();
        check("b2b e1 rdata", rdata_b, e);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 4'hE, 8'h00);
        exp_q.push_back(8'h11);
        @(posedge clk); #1;
        check("b2b e2 ready", ready_b, 1'b0);
        check("b2b e2 state", state_b, IDLE);
        @(posedge clk); #1;
        check("b2b e3 ready", ready_b, 1'b0);
        check("b2b e3 state", state_b, WAIT);
        @(posedge clk); #1;
        check("b2b e4 ready", ready_b, 1'b1);
        e = exp_q.pop_front();
        check("b2b e4 rdata", rdata_b, e);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk); #1;
        check("b2b pulse_end", ready_b, 1'b0);

        // Abort: valid dropped during WAIT
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'h1, 8'hFF);
        @(posedge clk); #1;
        check("abort accepted", state_a, WAIT);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_a) seen = 1'b1;
        end
        check("abort no_ready", seen, 1'b0);
        check("abort state", state_a, IDLE);
        do_req(1'b0, 1'b0, 4'h1, 8'h00, 8'h00, "abort rd1");

        // Reset in the middle of a write
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'h2, 8'h77);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst state", state_a, IDLE);
        check("midrst ready", ready_a, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready_a) seen = 1'b1;
        end
        check("midrst no_ready", seen, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 1'b0, 4'h2, 8'h00, 8'h00, "midrst rd2");
        do_req(1'b0, 1'b0, 4'h3, 8'h00, 8'h00, "midrst rd3_cleared");

        // Full sweep: write addr=data=i, then read all back
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b1, 4'(i), 8'(i), 8'h00, $sformatf("sweep wr%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b0, 4'(i), 8'h00, 8'(i), $sformatf("sweep rd%0d", i));
        end

        check("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
